// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART receiver: register offsets,
// STATUS bit positions and the receive FSM state type.
package uart_pkg;

  localparam logic [1:0] UART_RX_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_CTRL   = 2'd2;

  localparam int unsigned STATUS_VALID   = 0;
  localparam int unsigned STATUS_FULL    = 1;
  localparam int unsigned STATUS_OVERRUN = 2;
  localparam int unsigned STATUS_FRAME   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB compare.
module uart_rx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wptr;
  logic [PtrW:0]    rptr;
  logic             pop_eff;
  logic             push_eff;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PtrW] != rptr[PtrW]) && (wptr[PtrW-1:0] == rptr[PtrW-1:0]);
  assign rdata = mem[rptr[PtrW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // alongside a pop still lands.
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign overrun  = push & full & ~pop_eff;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_eff) begin
        mem[wptr[PtrW-1:0]] <= wdata;
        wptr <= wptr + 1'b1;
      end
      if (pop_eff) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: synchroniser, deframing FSM, RX FIFO,
// DATA/STATUS/CTRL registers and a level interrupt while data is pending.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int unsigned ClocksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW         = $clog2(ClocksPerBit) + 1;
  localparam logic [CntW-1:0] BitEnd   = CntW'(ClocksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd  = CntW'(ClocksPerBit / 2 - 1);

  logic            rx_meta;
  logic            rx_s;
  rx_state_e       state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push;
  logic            frame_set;

  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic        ovr_set;
  logic        pop;
  logic        overrun;
  logic        frame_err;
  logic        irq_en;
  logic [1:0]  offset;
  logic        wr_req;
  logic        stat_wr;
  logic [31:0] status_word;
  logic [31:0] read_word;
  logic        unused;

  assign unused = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                    device_wdata_i[31:4], device_wdata_i[1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == HalfEnd) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BitEnd) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BitEnd) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state == STOP && cnt == BitEnd) begin
      push      = rx_s;
      frame_set = ~rx_s;
    end
  end

  uart_rx_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .pop     (pop),
    .wdata   (shreg),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .overrun (ovr_set)
  );

  assign offset  = device_addr_i[3:2];
  assign wr_req  = device_req_i & device_we_i;
  assign pop     = device_req_i & ~device_we_i & (offset == UART_RX_DATA);
  assign stat_wr = wr_req & device_be_i[0] & (offset == UART_RX_STATUS);

  always_comb begin
    status_word                 = '0;
    status_word[STATUS_VALID]   = ~empty;
    status_word[STATUS_FULL]    = full;
    status_word[STATUS_OVERRUN] = overrun;
    status_word[STATUS_FRAME]   = frame_err;
  end

  always_comb begin
    read_word = '0;
    if (!device_we_i) begin
      unique case (offset)
        UART_RX_DATA:   read_word = empty ? '0 : {24'd0, head};
        UART_RX_STATUS: read_word = status_word;
        UART_RX_CTRL:   read_word = {31'd0, irq_en};
        default:        read_word = '0;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a W1C write wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      overrun   <= ovr_set   | (overrun   & ~(stat_wr & device_wdata_i[STATUS_OVERRUN]));
      frame_err <= frame_set | (frame_err & ~(stat_wr & device_wdata_i[STATUS_FRAME]));
      if (wr_req && device_be_i[0] && offset == UART_RX_CTRL) begin
        irq_en <= device_wdata_i[0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      rx_irq_o        <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) device_rdata_o <= read_word;
      rx_irq_o <= irq_en & ~empty;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver; the receive-side counterpart of the system's TX-only uart device.
- Samples the asynchronous serial input, deframes 8N1 characters and buffers them in a small FIFO.
- Exposes data and status registers on the standard device bus (req/we/be/addr/wdata, rvalid/rdata).
- Raises a level interrupt while data is available; the top level maps it at its own 4 KiB window and routes irq to irq_fast_i.

Parameters:
- ClockFrequency, 50_000_000, system clock in Hz.
- BaudRate, 115_200, serial bit rate.
- FifoDepth, 8, RX FIFO entries; power of two, at least 2.
- ClocksPerBit (localparam) = ClockFrequency / BaudRate, integer division (434 at defaults).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- device_req_i  input  1  bus request, single-cycle
- device_addr_i  input  32  byte address; only bits [3:2] decoded
- device_we_i  input  1  write enable
- device_be_i  input  4  byte enables
- device_wdata_i  input  32  write data
- device_rvalid_o  output  1  response valid, exactly 1 cycle after req
- device_rdata_o  output  32  read data, valid with rvalid
- uart_rx_i  input  1  serial input, asynchronous, idle high
- rx_irq_o  output  1  level interrupt

Behaviour:
- Reset (synchronous, rst_i=1 at clk_i edge):
  - outputs: rvalid=0, rdata=0, irq=0.
  - FSM=IDLE, FIFO empty, sticky flags clear, irq_en=0.
  - input synchroniser flops reset to 1.
- Reset mid-frame: the partial character is discarded and is never pushed.
- Input path: 2-flop synchroniser on uart_rx_i; all logic uses the synchronised value rx_s.
- FSM:
  - IDLE: when rx_s=0, clear the bit counter and go to START.
  - START: count ClocksPerBit/2 cycles, then sample rx_s.
    - rx_s=0: go to DATA with count restarted.
    - rx_s=1 (glitch): return to IDLE with no flag.
  - DATA: sample every ClocksPerBit cycles, shifting LSB first. After the 8th sample, go to STOP.
  - STOP: after ClocksPerBit cycles, sample rx_s.
    - rx_s=1: push the byte.
    - rx_s=0: set frame_err and discard the byte.
    - In both cases return to IDLE. A new start is detected no earlier than the following cycle.
- FIFO:
  - Push when full: byte dropped, overrun set.
  - Push and pop in the same cycle when full: both occur, no overrun.
  - Push and pop in the same cycle when empty: no pop; the push occurs.
- Register map (word offset addr[3:2]):
  - 0 DATA, RO: rdata[7:0] = FIFO head. A read pops. Read when empty returns 0 and does not pop. Writes are ignored.
  - 1 STATUS: bit0 valid (~empty), bit1 full, bit2 overrun, bit3 frame_err, others 0.
    - Write with be[0]=1: bits 2 and 3 are write-1-to-clear.
    - If set and clear occur in the same cycle, set wins.
  - 2 CTRL, RW: bit0 irq_en. Written only when be[0]=1. Reads return irq_en.
  - 3: reads return 0; writes are ignored.
- Bus timing:
  - Every req (read or write) gives rvalid=1 on the next cycle. No wait states, no error output.
  - rdata is the value captured at req time; it is 0 for writes.
  - A DATA pop takes effect at the req edge.
- Interrupt: rx_irq_o = irq_en & ~empty, registered (1-cycle lag).

Decomposition:
- uart_pkg holds:
  - register word offsets: UART_RX_DATA=0, UART_RX_STATUS=1, UART_RX_CTRL=2.
  - status bit-index constants.
  - the rx FSM state enum: IDLE, START, DATA, STOP.
- One sub-module, uart_rx_fifo:
  - synchronous FIFO with push/pop/full/empty.
  - pointers are log2(FifoDepth)+1 bits wide; wrap-around uses the MSB compare.

Test Plan (ClockFrequency=1_000_000, BaudRate=100_000, ClocksPerBit=10, FifoDepth=4):
- Send 0xA5 as 8N1 -> STATUS=0x1; a DATA read returns 0xA5 with rvalid 1 cycle after req; STATUS then reads 0x0.
- Set CTRL=1, send 0x3C -> irq rises ≤2 cycles after the stop-bit sample; after the DATA read, irq=0 within 2 cycles.
- Send 5 bytes 0x01..0x05 without reads -> STATUS=0x7; reads return 0x01..0x04 then 0x00; write STATUS=0x4 -> overrun clears.
- Send 0x55 with stop bit = 0 -> STATUS=0x8, FIFO empty; write 0x8 -> STATUS=0x0.
- Pulse uart_rx_i low for 3 cycles -> FSM returns to IDLE; no byte and no flags.
- Assert rst_i during the 4th data bit of 0xFF -> all outputs 0 and STATUS=0x0. A following 0x12 frame is received correctly.
